// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions used by the adder and multiplier issue/writeback paths.
package fp_pkg;

  localparam int FP_W        = 32;
  localparam int FPADD_LAT   = 3;
  localparam int FP_TAG_W    = 5;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;
  localparam int FP_MAN_LSB  = 0;
  localparam int FP_EXP_W    = FP_EXP_MSB - FP_EXP_LSB + 1;
  localparam int FP_MAN_W    = FP_MAN_MSB - FP_MAN_LSB + 1;

  // Writeback record for the FP register file at the default tag width
  typedef struct packed {
    logic [FP_W-1:0]     data;
    logic [FP_TAG_W-1:0] rd;
  } fp_wb_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] f);
    return f[FP_SIGN_BIT];
  endfunction

  function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_W-1:0] f);
    return f[FP_EXP_MSB:FP_EXP_LSB];
  endfunction

  function automatic logic [FP_MAN_W-1:0] fp_man(input logic [FP_W-1:0] f);
    return f[FP_MAN_MSB:FP_MAN_LSB];
  endfunction

endpackage

// File: rtl/fpadd_issue_wb_if.sv
// Issue request and writeback bus between the FP issue logic and the adder sequencer.
interface fpadd_issue_wb_if
  import fp_pkg::*;
#(
  parameter int TAG_W = FP_TAG_W
);

  logic             issue_valid;
  logic             issue_ready;
  logic [FP_W-1:0]  issue_rs1;
  logic [FP_W-1:0]  issue_rs2;
  logic [TAG_W-1:0] issue_rd;

  logic             wb_valid;
  logic             wb_ready;
  logic [FP_W-1:0]  wb_data;
  logic [TAG_W-1:0] wb_rd;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, wb_ready,
    input  issue_ready, wb_valid, wb_data, wb_rd
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, wb_ready,
    output issue_ready, wb_valid, wb_data, wb_rd
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; a pushed entry becomes visible at the head one cycle later.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Guards keep the pointers coherent even if a caller misbehaves
  assign do_push = push & (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fpadd_issue_wb.sv
// Issue/writeback sequencer around the fixed-latency FP adder core: tracks in-flight tags
// and reserves a result FIFO slot for every accepted op, since the core cannot stall.
module fpadd_issue_wb
  import fp_pkg::*;
#(
  parameter int LAT   = FPADD_LAT,
  parameter int DEPTH = 8,
  parameter int TAG_W = FP_TAG_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  fpadd_issue_wb_if.slave bus,
  output logic [FP_W-1:0] add_rs1,
  output logic [FP_W-1:0] add_rs2,
  input  logic [FP_W-1:0] add_out,
  output logic            busy
);

  localparam int RESV_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [FP_W-1:0]  data;
    logic [TAG_W-1:0] rd;
  } wb_rec_t;

  logic                        fire;
  logic                        pop;
  logic                        capture;
  logic [RESV_W-1:0]           resv_q, resv_d;
  logic [LAT-1:0]              pipe_v_q, pipe_v_d;
  logic [LAT-1:0][TAG_W-1:0]   pipe_rd_q, pipe_rd_d;
  wb_rec_t                     wr_rec;
  wb_rec_t                     head_rec;
  logic [RESV_W-1:0]           fifo_count;

  // Readiness comes only from registered state and flush, never from wb_ready
  assign bus.issue_ready = resetn & ~flush & (resv_q < RESV_W'(DEPTH));
  assign fire            = bus.issue_valid & bus.issue_ready;
  assign pop             = bus.wb_valid & bus.wb_ready & ~flush;
  assign capture         = pipe_v_q[LAT-1] & ~flush;

  assign add_rs1 = bus.issue_rs1;
  assign add_rs2 = bus.issue_rs2;

  always_comb begin
    pipe_v_d     = pipe_v_q;
    pipe_rd_d    = pipe_rd_q;
    pipe_v_d[0]  = fire;
    pipe_rd_d[0] = bus.issue_rd;
    for (int i = 1; i < LAT; i++) begin
      pipe_v_d[i]  = pipe_v_q[i-1];
      pipe_rd_d[i] = pipe_rd_q[i-1];
    end
    if (flush) begin
      pipe_v_d = '0;
    end
  end

  // Counts in-flight plus buffered results, so a slot exists for every core output
  always_comb begin
    resv_d = resv_q;
    if (flush) begin
      resv_d = '0;
    end else begin
      resv_d = resv_q + RESV_W'(fire) - RESV_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pipe_v_q  <= '0;
      pipe_rd_q <= '0;
      resv_q    <= '0;
    end else begin
      pipe_v_q  <= pipe_v_d;
      pipe_rd_q <= pipe_rd_d;
      resv_q    <= resv_d;
    end
  end

  assign wr_rec.data = add_out;
  assign wr_rec.rd   = pipe_rd_q[LAT-1];

  sync_fifo #(
    .WIDTH ($bits(wb_rec_t)),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (capture),
    .push_data (wr_rec),
    .pop       (pop),
    .head      (head_rec),
    .count     (fifo_count)
  );

  assign bus.wb_valid = (fifo_count != '0);
  assign bus.wb_data  = head_rec.data;
  assign bus.wb_rd    = head_rec.rd;
  assign busy         = (resv_q != '0);

endmodule

// File: doc/fpadd_issue_wb.md
# fpadd_issue_wb

Issue and writeback sequencer around the fixed-latency FP adder core. The core is a single-precision IEEE 754 adder with three stages, no stall and no valid signal. This block accepts tagged add requests over a valid/ready handshake and drives the core's operands. It tracks each operation's valid bit and destination tag through a shift register matched to the core's latency, then buffers results in a FIFO for the FP register-file writeback port. A reservation counter guarantees that every in-flight result has a FIFO slot, because the core cannot be back-pressured.

## Interface
Parameters:
- LAT, 3, core latency in cycles (operands presented in cycle N, core output valid in cycle N+LAT)
- DEPTH, 8, result FIFO entries; power of two, at least 2
- TAG_W, 5, destination tag width (FP register index)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous kill of all in-flight and buffered results
- issue_valid  in  1  request valid
- issue_ready  out  1  request accepted when both valid and ready are high ("fire")
- issue_rs1, issue_rs2  in  32  operands
- issue_rd  in  TAG_W  destination tag
- add_rs1, add_rs2  out  32  to the core; combinational copies of issue_rs1/issue_rs2
- add_out  in  32  core result
- wb_valid  out  1  FIFO head valid
- wb_ready  in  1  writeback accepts; pop = wb_valid & wb_ready
- wb_data  out  32  head result
- wb_rd  out  TAG_W  head tag
- busy  out  1  reserved count != 0

## Operation
- Tracking pipe: LAT entries of {v, rd}. Each cycle, stage 0 loads {fire, issue_rd} and the other stages shift. When the stage LAT-1 entry has v=1, add_out and its tag are written into the FIFO in that cycle.
- FIFO: registered storage with wr_ptr, rd_ptr and a count. Pointers wrap modulo DEPTH. The head is visible as wb_data/wb_rd. There is no bypass: a result written in cycle M appears on wb_valid in cycle M+1.
- Reservation counter `resv` (width clog2(DEPTH+1)) counts in-flight plus buffered results:
  - fire increments it; pop decrements it; simultaneous fire and pop leaves it unchanged.
- issue_ready = (resv < DEPTH) & !flush. It depends on registered state and flush only; there is no combinational path from wb_ready.
- FIFO overflow is impossible by construction. The verification bench asserts count <= resv <= DEPTH.
- Flush cycle:
  - All pipe v bits, FIFO pointers, count and resv clear at the clock edge.
  - issue_ready is low, so there is no fire.
  - Pop is ignored even if wb_valid & wb_ready; the writeback side must tolerate wb_valid dropping.
  - Any capture from the pipe in that cycle is discarded.
- The core is never gated. When not firing, the core computes garbage, and that garbage is masked by v=0.

## Timing
- Reset (resetn low at the edge) sets: issue_ready=0 during reset, 1 in the first cycle after; wb_valid=0; wb_data=0; wb_rd=0; busy=0; all v=0; resv=0.
- Fire in cycle N: capture in cycle N+LAT, wb_valid in cycle N+LAT+1 (4 cycles with the defaults).
- Sustained throughput with wb_ready held high is 1 op per cycle when DEPTH >= LAT+2. With DEPTH <= LAT+1, issue_ready periodically drops.
- With wb_ready held low, at most DEPTH fires are accepted. issue_ready falls in the cycle after the DEPTH-th fire and stays low until the first pop. Results held in the FIFO stay stable.
- In-order completion: results leave in issue order.
- Reset or flush mid-operation: no result issued before the edge ever appears on wb_valid.

## Structure
- Shared package fp_pkg holds:
  - FP_W=32
  - FPADD_LAT=3 (default for LAT)
  - sign/exponent/mantissa field slices
  - the writeback record type {data[31:0], rd[TAG_W-1:0]}
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, flush, count, head out), reused by the multiplier writeback path.
- The tracking pipe and resv counter live in the top level.

## Test plan
- Single op: after reset, fire rs1=0x3F800000, rs2=0x3F800000, rd=3 in cycle N -> wb_valid first high in cycle N+4, wb_data=0x40000000, wb_rd=3, busy=0 after the pop.
- Back-to-back: 16 fires, one per cycle, computing 2.0+1.0 (0x40000000+0x3F800000), rd=0..15, wb_ready=1 -> issue_ready never drops; 16 results all 0x40400000 in rd order 0..15, one per cycle.
- Backpressure: wb_ready=0, issue_valid held high -> exactly 8 fires accepted, issue_ready low from the next cycle. Raise wb_ready -> the 8 results drain in order and issue_ready returns to 1 the cycle after the first pop.
- Simultaneous fire and pop with resv=8 -> fire rejected (issue_ready=0). With resv=7 and a pop in the same cycle -> fire accepted and resv stays 7.
- Flush with 3 ops in flight and 2 buffered -> the next cycle shows wb_valid=0 and resv=0. No stale result appears within 10 cycles, and a fresh op completes correctly with 4-cycle latency.
- Reset asserted mid-stream with the FIFO half full -> all outputs take their reset values the next cycle, and no pre-reset result is ever emitted.
